// File: rtl/pc_step_counter_pkg.sv
// Shared types, default sizes and step helper for the pc_step_counter block.
package pc_step_counter_pkg;

  typedef enum logic {
    STEP_2 = 1'b0,
    STEP_4 = 1'b1
  } step_e;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_WRAP_W = 4;

  // Increment magnitude for a step selector; a counter narrower than 3 bits cannot hold 4.
  function automatic int unsigned step_value(step_e sel, int width);
    if (sel == STEP_4 && width >= 3) begin
      return 4;
    end
    return 2;
  endfunction

endpackage

// File: rtl/pc_step_adder.sv
// Ripple-carry adder for the step counter; with PC_STEP_COUNTER_DOWN_EN it also subtracts.
// wrap reports carry-out when adding and borrow-out when subtracting.
module pc_step_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef PC_STEP_COUNTER_DOWN_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             wrap
);

  // Subtraction is a + ~b + 1, so a missing carry-out means a borrow.
  always_comb begin
    logic [WIDTH-1:0] b_eff;
    logic             carry;
`ifdef PC_STEP_COUNTER_DOWN_EN
    b_eff = b ^ {WIDTH{sub}};
    carry = sub;
`else
    b_eff = b;
    carry = 1'b0;
`endif
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ carry;
      carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
`ifdef PC_STEP_COUNTER_DOWN_EN
    wrap = sub ? ~carry : carry;
`else
    wrap = carry;
`endif
  end

endmodule

// File: rtl/pc_step_counter.sv
// Halfword-aligned program-counter step counter with load, wrap pulse and saturating wrap count.
// Define PC_STEP_COUNTER_DOWN_EN to add the dir_i port and the down-counting path.
module pc_step_counter
  import pc_step_counter_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               WRAP_W    = DEFAULT_WRAP_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              step_sel_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic              clr_wrap_i,
`ifdef PC_STEP_COUNTER_DOWN_EN
  input  logic              dir_i,
`endif
  output logic [WIDTH-1:0]  cnt_o,
  output logic [WIDTH-1:0]  cnt_next_o,
  output logic              wrap_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  localparam logic [WIDTH-1:0]  ALIGN_MASK = ~WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_MAX   = '1;

  logic [WIDTH-1:0]  cnt_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wrap_cnt_q;

  logic [WIDTH-1:0]  step;
  logic [WIDTH-1:0]  sum;
  logic              adder_wrap;

  logic [WIDTH-1:0]  cnt_d;
  logic              wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_d;

  assign step = WIDTH'(step_value(step_e'(step_sel_i), WIDTH));

  pc_step_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (cnt_q),
    .b    (step),
`ifdef PC_STEP_COUNTER_DOWN_EN
    .sub  (dir_i),
`endif
    .sum  (sum),
    .wrap (adder_wrap)
  );

  // Load beats enable; bit 0 of every stored value is forced low to keep halfword alignment.
  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    if (load_i) begin
      cnt_d = load_val_i & ALIGN_MASK;
    end else if (en_i) begin
      cnt_d  = sum & ALIGN_MASK;
      wrap_d = adder_wrap;
    end
    if (clr_wrap_i) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && wrap_cnt_q != WRAP_MAX) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= RESET_VAL & ALIGN_MASK;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = sum;
  assign wrap_o     = wrap_q;
  assign wrap_cnt_o = wrap_cnt_q;

endmodule

// File: tb/tb_pc_step_counter.sv
// Self-checking bench for pc_step_counter: directed table, corner sequences and random traffic
// against an arithmetic reference model.
module tb_pc_step_counter;

  localparam int          WIDTH     = 32;
  localparam int          WRAP_W    = 4;
  localparam logic [31:0] RESET_VAL = 32'h0000_0100;
  localparam int          WRAP_SAT  = 15;

  logic              clk;
  logic              rst;
  logic              en;
  logic              step_sel;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_wrap;
  logic              dir;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  cnt_next;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] m_cnt;
  logic        m_wrap;
  int          m_wrap_cnt;

  typedef struct {
    string       name;
    logic        en;
    logic        sel;
    logic        load;
    logic [31:0] val;
    logic        clr;
    logic [31:0] exp_cnt;
    logic        exp_wrap;
    int          exp_wrap_cnt;
  } vec_t;

  pc_step_counter #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .WRAP_W    (WRAP_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .step_sel_i (step_sel),
    .load_i     (load),
    .load_val_i (load_val),
    .clr_wrap_i (clr_wrap),
`ifdef PC_STEP_COUNTER_DOWN_EN
    .dir_i      (dir),
`endif
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next),
    .wrap_o     (wrap),
    .wrap_cnt_o (wrap_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic is_down(input logic d);
`ifdef PC_STEP_COUNTER_DOWN_EN
    return d;
`else
    return 1'b0 & d;
`endif
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] c, input logic sel, input logic d);
    longint unsigned s = sel ? 4 : 2;
    if (is_down(d)) return c - 32'(s);
    return 32'(longint'(c) + s);
  endfunction

  task automatic model_reset();
    m_cnt      = RESET_VAL;
    m_wrap     = 1'b0;
    m_wrap_cnt = 0;
  endtask

  task automatic model_edge(input logic e, input logic sel, input logic ld,
                            input logic [31:0] val, input logic clr, input logic d);
    longint unsigned s = sel ? 4 : 2;
    longint unsigned total;
    if (ld) begin
      m_cnt  = {val[31:1], 1'b0};
      m_wrap = 1'b0;
    end else if (e) begin
      if (is_down(d)) begin
        m_wrap = (longint'(m_cnt) < s);
        m_cnt  = m_cnt - 32'(s);
      end else begin
        total  = longint'(m_cnt) + s;
        m_wrap = (total > 64'h0000_0000_FFFF_FFFF);
        m_cnt  = total[31:0];
      end
    end else begin
      m_wrap = 1'b0;
    end
    if (clr) m_wrap_cnt = 0;
    else if (m_wrap && m_wrap_cnt < WRAP_SAT) m_wrap_cnt++;
  endtask

  task automatic checkOutput(input string name);
    compare({name, ".cnt"}, 64'(cnt), 64'(m_cnt));
    compare({name, ".wrap"}, 64'(wrap), 64'(m_wrap));
    compare({name, ".wrap_cnt"}, 64'(wrap_cnt), 64'(m_wrap_cnt));
  endtask

  // Drive one cycle's inputs, check the combinational next value, clock, then check the registers.
  task automatic applyStimulus(input string name, input logic e, input logic sel, input logic ld,
                               input logic [31:0] val, input logic clr, input logic d);
    en       = e;
    step_sel = sel;
    load     = ld;
    load_val = val;
    clr_wrap = clr;
    dir      = d;
    #1;
    compare({name, ".cnt_next"}, 64'(cnt_next), 64'(model_next(m_cnt, sel, d)));
    @(posedge clk);
    #1;
    model_edge(e, sel, ld, val, clr, d);
    checkOutput(name);
  endtask

  vec_t vecs[$];

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    step_sel = 1'b0;
    load     = 1'b0;
    load_val = '0;
    clr_wrap = 1'b0;
    dir      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;

    vecs.push_back('{"inc2_a",  1, 0, 0, 32'h0,         0, 32'h0000_0102, 0, 0});
    vecs.push_back('{"inc2_b",  1, 0, 0, 32'h0,         0, 32'h0000_0104, 0, 0});
    vecs.push_back('{"inc2_c",  1, 0, 0, 32'h0,         0, 32'h0000_0106, 0, 0});
    vecs.push_back('{"load_en", 1, 0, 1, 32'h1235,      0, 32'h0000_1234, 0, 0});
    vecs.push_back('{"hold",    0, 1, 0, 32'h0,         0, 32'h0000_1234, 0, 0});
    vecs.push_back('{"ld_top",  0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0});
    vecs.push_back('{"wrap4",   1, 1, 0, 32'h0,         0, 32'h0000_0000, 1, 1});
    vecs.push_back('{"pulse",   0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 1});
    vecs.push_back('{"inc4",    1, 1, 0, 32'h0,         0, 32'h0000_0004, 0, 1});
    vecs.push_back('{"clr",     0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 0});
    vecs.push_back('{"ld_odd",  0, 0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 0, 0});
    vecs.push_back('{"wrap2",   1, 0, 0, 32'h0,         0, 32'h0000_0000, 1, 1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].en, vecs[i].sel, vecs[i].load,
                    vecs[i].val, vecs[i].clr, 1'b0);
      compare({vecs[i].name, ".tbl_cnt"}, 64'(cnt), 64'(vecs[i].exp_cnt));
      compare({vecs[i].name, ".tbl_wrap"}, 64'(wrap), 64'(vecs[i].exp_wrap));
      compare({vecs[i].name, ".tbl_wcnt"}, 64'(wrap_cnt), 64'(vecs[i].exp_wrap_cnt));
    end

    // Twenty wraps must pin the counter at its maximum.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat_ld", 0, 0, 1, 32'hFFFF_FFFC, 0, 1'b0);
      applyStimulus("sat_wr", 1, 1, 0, 32'h0, 0, 1'b0);
    end
    compare("sat_value", 64'(wrap_cnt), 64'(WRAP_SAT));

    applyStimulus("clrw_ld", 0, 0, 1, 32'hFFFF_FFFC, 0, 1'b0);
    applyStimulus("clrw_wr", 1, 1, 0, 32'h0, 1, 1'b0);
    compare("clr_beats_wrap", 64'(wrap_cnt), 64'(0));
    compare("clr_wrap_pulse", 64'(wrap), 64'(1));

    // Holding with a toggling step select moves only the combinational next value.
    applyStimulus("tog_ld", 0, 0, 1, 32'h0000_8000, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step_sel = i[0];
      en       = 1'b0;
      load     = 1'b0;
      #1;
      compare("tog_next", 64'(cnt_next), 64'(32'h0000_8000 + (i[0] ? 32'd4 : 32'd2)));
      @(posedge clk);
      #1;
      compare("tog_hold", 64'(cnt), 64'(32'h0000_8000));
    end

`ifdef PC_STEP_COUNTER_DOWN_EN
    applyStimulus("dn_ld", 0, 0, 1, 32'h2, 0, 1'b0);
    applyStimulus("dn_borrow", 1, 1, 0, 32'h0, 0, 1'b1);
    compare("dn_cnt", 64'(cnt), 64'(32'hFFFF_FFFE));
    compare("dn_wrap", 64'(wrap), 64'(1));
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(3) == 0) v = 32'hFFFF_FFF0 | (v & 32'hF);
      else if ($urandom_range(3) == 0) v = v & 32'hF;
      applyStimulus("rand", $urandom_range(3) != 0, 1'($urandom), $urandom_range(7) == 0,
                    v, $urandom_range(15) == 0, 1'($urandom));
    end

    // Reset mid-stream takes effect before the next clock edge.
    applyStimulus("mid_run", 1, 1, 0, 32'h0, 0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("post_rst", 1, 0, 0, 32'h0, 0, 1'b0);
    compare("post_rst_val", 64'(cnt), 64'(32'h0000_0102));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_step_counter.md
# pc_step_counter

Parametrised, registered program-counter style step counter: holds a WIDTH-bit halfword-aligned value and advances it by 2 or 4 per enabled cycle, with a prioritised synchronous load. It also provides a combinational next-value output, a wrap pulse and a saturating wrap counter. It generalises the fixed 32-bit fetch-address incrementer into a configurable, stateful block for the instruction-fetch path and for module-identification test designs.

## Interface
- WIDTH, 32, counter width in bits (≥ 4)
- RESET_VAL, 0, value of cnt_o after reset (bit 0 must be 0)
- WRAP_W, 4, width of wrap_cnt_o
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- en_i  in  1  advance counter this cycle
- step_sel_i  in  1  0: step 2, 1: step 4
- load_i  in  1  load load_val_i this cycle
- load_val_i  in  WIDTH  load value (bit 0 ignored)
- clr_wrap_i  in  1  clear wrap_cnt_o
- dir_i  in  1  0: up, 1: down (present only with PC_STEP_COUNTER_DOWN_EN)
- cnt_o  out  WIDTH  current registered value
- cnt_next_o  out  WIDTH  combinational cnt_o ± step
- wrap_o  out  1  registered one-cycle wrap pulse
- wrap_cnt_o  out  WRAP_W  saturating count of wraps

## Operation
- Reset values: cnt_o = RESET_VAL, wrap_o = 0, wrap_cnt_o = 0.
- Step = 2 when step_sel_i = 0, 4 when 1. cnt_next_o = cnt_o + step mod 2^WIDTH (down: cnt_o − step). It is valid every cycle, regardless of en_i.
- Per-edge priority: load_i > en_i > hold.
  - load_i: cnt_o ← {load_val_i[WIDTH-1:1], 0}. wrap_o ← 0.
  - en_i without load: cnt_o ← cnt_next_o. wrap_o ← carry-out (up) or borrow-out (down) of the WIDTH-bit add.
  - Otherwise: cnt_o holds and wrap_o ← 0.
- cnt_o[0] is 0 at all times.
- wrap_cnt_o:
  - clr_wrap_i → 0. Clear wins over a simultaneous wrap.
  - Otherwise increments when the wrap_o next-value is 1.
  - Saturates at 2^WRAP_W − 1 and never rolls over.
- Arithmetic is unsigned. The step is zero-extended to WIDTH. There is no signed overflow detection.

## Timing
- cnt_o and wrap_o update one cycle after the en_i/load_i edge that causes them.
- cnt_next_o has zero latency from cnt_o and step_sel_i.
- wrap_cnt_o reflects a wrap in the same cycle that wrap_o asserts.
- Reset mid-operation: all outputs return to their reset values asynchronously. The first enabled edge after deassertion advances from RESET_VAL.

## Configuration
- PC_STEP_COUNTER_DOWN_EN defined:
  - dir_i port exists and selects add or subtract.
  - A borrow (cnt_o < step while decrementing) sets wrap_o.
- Not defined:
  - No dir_i port; the counter is up-only.
  - The subtract path is absent from the netlist.

## Structure
- Package pc_step_counter_pkg holds:
  - step_e enum (STEP_2 = 1'b0, STEP_4 = 1'b1)
  - default WIDTH and WRAP_W constants
  - function step_value(step_e, width)
- Sub-module pc_step_adder: combinational WIDTH-bit ripple adder/subtractor with explicit per-bit carry, so synthesis maps it onto a carry chain. It produces cnt_next_o and the carry/borrow out. The top level holds the registers, priority logic and wrap counter.

## Test plan
- Reset with RESET_VAL = 32'h0000_0100 → cnt_o = 0x100, wrap_o = 0, wrap_cnt_o = 0. Then en_i = 1, step_sel_i = 0 for 3 cycles → cnt_o = 0x106.
- load_i = 1 and en_i = 1 together, load_val_i = 0x1235 → next cnt_o = 0x1234, no increment, wrap_o = 0.
- Load 0xFFFF_FFFC, en_i = 1, step_sel_i = 1 → cnt_o = 0x0, wrap_o = 1 for exactly one cycle, wrap_cnt_o = 1.
- Wrap 20 times with WRAP_W = 4 → wrap_cnt_o saturates at 15. Then clr_wrap_i coinciding with a wrap → wrap_cnt_o = 0.
- en_i = 0 with step_sel_i toggling → cnt_o holds, cnt_next_o alternates between cnt_o + 2 and cnt_o + 4 combinationally.
- PC_STEP_COUNTER_DOWN_EN: load 0x2, dir_i = 1, step 4 → cnt_o = 0xFFFF_FFFE, wrap_o = 1. Assert rst_i mid-stream → cnt_o = RESET_VAL immediately.
